seq_alu: RTL and testbench

//   Parametrised, registered ALU with valid/ready handshakes on input and output.
//   It extends the 4-op AND/OR/ADD/SUB ALU with XOR, shifts, SLT, carry and overflow

---
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: operand/op request channel plus result/flag response channel.
// The master drives requests and out_ready; the slave (the ALU) drives in_ready and the result side.
interface seq_alu_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         illegal;

    modport master (
        output in_valid, op_a, op_b, op, out_ready,
        input  in_ready, out_valid, res, zero, carry, ovf, illegal
    );

    modport slave (
        input  in_valid, op_a, op_b, op, out_ready,
        output in_ready, out_valid, res, zero, carry, ovf, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides; one result register, IDLE/BUSY/DONE control.
// Build option ALU_MUL_EN adds an iterative radix-2 multiplier for op 8 (otherwise op 8 is illegal).
module seq_alu #(
    parameter int W   = 64,
    parameter int SHW = $clog2(W)
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(W - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] res_q, res_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic         ovf_q, ovf_d;
    logic         illegal_q, illegal_d;

`ifdef ALU_MUL_EN
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [W-1:0]   acc_step;
`endif

    logic         in_ready;
    logic         accept;
    logic         take_alu;

    logic [W:0]   sum_w;
    logic [W:0]   diff_w;
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic         alu_ovf;
    logic         alu_illegal;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Single-cycle datapath works straight off the bus so the result lands in the register on accept.
    always_comb begin
        sum_w       = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        diff_w      = {1'b0, bus.op_a} - {1'b0, bus.op_b};
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (bus.op)
            OP_AND: alu_res = bus.op_a & bus.op_b;
            OP_OR:  alu_res = bus.op_a | bus.op_b;
            OP_XOR: alu_res = bus.op_a ^ bus.op_b;
            OP_ADD: begin
                alu_res   = sum_w[W-1:0];
                alu_carry = sum_w[W];
                alu_ovf   = (bus.op_a[W-1] == bus.op_b[W-1]) && (sum_w[W-1] != bus.op_a[W-1]);
            end
            OP_SUB: begin
                alu_res   = diff_w[W-1:0];
                alu_carry = diff_w[W];
                alu_ovf   = (bus.op_a[W-1] != bus.op_b[W-1]) && (diff_w[W-1] != bus.op_a[W-1]);
            end
            OP_SLL: alu_res = bus.op_a << bus.op_b[SHW-1:0];
            OP_SRL: alu_res = bus.op_a >> bus.op_b[SHW-1:0];
            OP_SLT: alu_res = {{(W-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        take_alu  = 1'b0;
`ifdef ALU_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE, DONE: begin
                take_alu = accept;
`ifdef ALU_MUL_EN
                if (accept && (bus.op == OP_MUL)) begin
                    take_alu = 1'b0;
                    state_d  = BUSY;
                    acc_d    = '0;
                    mcand_d  = bus.op_a;
                    mplier_d = bus.op_b;
                    cnt_d    = '0;
                end
`endif
                if (take_alu) begin
                    state_d   = DONE;
                    res_d     = alu_res;
                    zero_d    = (alu_res == '0);
                    carry_d   = alu_carry;
                    ovf_d     = alu_ovf;
                    illegal_d = alu_illegal;
                end else if (!accept && (state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                // One multiplier bit per cycle; only the low W product bits are kept.
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    res_d     = acc_step;
                    zero_d    = (acc_step == '0);
                    carry_d   = 1'b0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            res_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.res       = res_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at W=8: directed corner cases then randomized traffic with random backpressure.
module tb_seq_alu;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        bit           zero;
        bit           carry;
        bit           ovf;
        bit           illegal;
        int           lat;
        int           first;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.W(W)) ifc ();
    seq_alu #(.W(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    bit   discard = 1'b0;
    bit   rand_mode = 1'b0;
    bit   or_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        ifc.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : or_force;
    end

    // Reference: plain integer arithmetic on unsigned and two's-complement views of the operands.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   m;
        int   half;
        int   sa;
        int   sb;
        int   r;
        m = (1 << W) - 1;
        half = 1 << (W - 1);
        sa = (a >= half) ? a - (1 << W) : a;
        sb = (b >= half) ? b - (1 << W) : b;
        e.lat = 1; e.carry = 0; e.ovf = 0; e.illegal = 0; e.first = 0;
        r = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin
                r = a + b;
                e.carry = (r > m);
                e.ovf = (sa + sb >= half) || (sa + sb < -half);
            end
            3: r = a ^ b;
            4: r = a << (b % W);
            5: r = a >> (b % W);
            6: begin
                r = a - b;
                e.carry = (a < b);
                e.ovf = (sa - sb >= half) || (sa - sb < -half);
            end
            7: r = (sa < sb) ? 1 : 0;
`ifdef ALU_MUL_EN
            8: begin r = a * b; e.lat = W + 1; end
`endif
            default: e.illegal = 1;
        endcase
        e.res = W'(r & m);
        e.zero = (e.res == 0);
        e.name = $sformatf("op%0d_%02h_%02h", op, a, b);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input bit z, input bit c, input bit o,
                                input bit il, input int lat, input string n);
        exp_t e;
        e.res = r; e.zero = z; e.carry = c; e.ovf = o; e.illegal = il;
        e.lat = lat; e.first = 0; e.name = n;
        return e;
    endfunction

    // Monitor: expected out_valid/in_ready derive from the scoreboard, values from its head.
    always @(negedge clk) begin
        bit exp_v;
        bit exp_rdy;
        if (!rst && !discard) begin
            exp_v = (q.size() > 0) && (cyc >= q[0].first);
            exp_rdy = (q.size() == 0) || (exp_v && (ifc.out_ready === 1'b1));
            checks++;
            if (ifc.out_valid !== exp_v) begin
                errors++;
                $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, ifc.out_valid, exp_v);
            end
            checks++;
            if (ifc.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, ifc.in_ready, exp_rdy);
            end
            if (exp_v && (ifc.out_valid === 1'b1)) begin
                checks++;
                if ((ifc.res !== q[0].res) || (ifc.zero !== q[0].zero) || (ifc.carry !== q[0].carry) ||
                    (ifc.ovf !== q[0].ovf) || (ifc.illegal !== q[0].illegal)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got res=%h z/c/o/i=%b%b%b%b expected res=%h z/c/o/i=%b%b%b%b",
                             q[0].name, cyc, ifc.res, ifc.zero, ifc.carry, ifc.ovf, ifc.illegal,
                             q[0].res, q[0].zero, q[0].carry, q[0].ovf, q[0].illegal);
                end
                if (ifc.out_ready === 1'b1) void'(q.pop_front());
            end
        end
    end

    task automatic do_op(input int op, input int a, input int b, input exp_t e, input bit push,
                         output int acc_cyc);
        bit ok;
        ok = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.op = 4'(op);
        ifc.op_a = W'(a);
        ifc.op_b = W'(b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout %s: in_ready never 1 within 100 cycles, required 1", e.name);
        end else if (push) begin
            e.first = acc_cyc + e.lat;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   t0;
        int   t1;
        int   op;
        int   a;
        int   b;
        exp_t e;
        ifc.in_valid = 1'b0;
        ifc.op = '0;
        ifc.op_a = '0;
        ifc.op_b = '0;

        // 1: reset held, then state right after release
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ((ifc.res !== 8'h00) || (ifc.zero !== 1'b0) || (ifc.carry !== 1'b0) ||
            (ifc.ovf !== 1'b0) || (ifc.illegal !== 1'b0) || (ifc.out_valid !== 1'b0) ||
            (ifc.in_ready !== 1'b1)) begin
            errors++;
            $display("FAIL reset_state: got res=%h z/c/o/i=%b%b%b%b ov=%b ir=%b expected res=00 0000 ov=0 ir=1",
                     ifc.res, ifc.zero, ifc.carry, ifc.ovf, ifc.illegal, ifc.out_valid, ifc.in_ready);
        end
        @(posedge clk);
        #1;

        // 2, 3: arithmetic flag corners
        or_force = 1'b1;
        do_op(2, 8'h7F, 8'h01, mk(8'h80, 0, 0, 1, 0, 1, "add_7f_01"), 1'b1, t0);
        do_op(6, 8'h00, 8'h01, mk(8'hFF, 0, 1, 0, 0, 1, "sub_00_01"), 1'b1, t0);
        do_op(6, 8'h05, 8'h05, mk(8'h00, 1, 0, 0, 0, 1, "sub_05_05"), 1'b1, t0);
        do_op(7, 8'h80, 8'h01, mk(8'h01, 0, 0, 0, 0, 1, "slt_80_01"), 1'b1, t0);
        do_op(5, 8'h80, 8'h0F, mk(8'h01, 0, 0, 0, 0, 1, "srl_80_by7"), 1'b1, t0);
        do_op(12, 8'h12, 8'h34, mk(8'h00, 1, 0, 0, 1, 1, "illegal_12"), 1'b1, t0);
        drain();

        // 4: hold under backpressure, then accept alongside out_ready and stream back-to-back
        or_force = 1'b0;
        do_op(2, 8'h12, 8'h34, mk(8'h46, 0, 0, 0, 0, 1, "add_hold"), 1'b1, t0);
        repeat (5) @(posedge clk);
        #1 or_force = 1'b1;
        do_op(0, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0, 1, "and_b2b0"), 1'b1, t0);
        do_op(0, 8'hFF, 8'h0F, mk(8'h0F, 0, 0, 0, 0, 1, "and_b2b1"), 1'b1, t1);
        checks++;
        if (t1 - t0 != 1) begin
            errors++;
            $display("FAIL back_to_back: accept spacing %0d cycles, required 1", t1 - t0);
        end
        t0 = t1;
        do_op(3, 8'hAA, 8'h55, mk(8'hFF, 0, 0, 0, 0, 1, "xor_b2b2"), 1'b1, t1);
        checks++;
        if (t1 - t0 != 1) begin
            errors++;
            $display("FAIL back_to_back2: accept spacing %0d cycles, required 1", t1 - t0);
        end
        drain();

        // 5: multiply (or illegal when compiled out)
`ifdef ALU_MUL_EN
        do_op(8, 13, 11, mk(8'h8F, 0, 0, 0, 0, W + 1, "mul_13_11"), 1'b1, t0);
`else
        do_op(8, 13, 11, mk(8'h00, 1, 0, 0, 1, 1, "mul_13_11_illegal"), 1'b1, t0);
`endif
        drain();

        // 6: reset during a multiply discards it; next op behaves normally
        or_force = 1'b0;
        discard = 1'b1;
        do_op(8, 8'h21, 8'h07, mk(8'h00, 0, 0, 0, 0, 1, "mul_discard"), 1'b0, t0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        discard = 1'b0;
        or_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_op(4, 8'h01, 8'h03, mk(8'h08, 0, 0, 0, 0, 1, "sll_01_by3"), 1'b1, t0);
        drain();

        // Randomized traffic with random backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 8);
            case ($urandom_range(0, 5))
                0: a = 8'h7F;
                1: a = 8'h80;
                2: a = 8'hFF;
                default: a = $urandom_range(0, 255);
            endcase
            b = ($urandom_range(0, 5) == 0) ? a : $urandom_range(0, 255);
            e = model(op, a, b);
            do_op(op, a, b, e, 1'b1, t0);
        end
        #1 rand_mode = 1'b0;
        or_force = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
